seq_multiplier_n: RTL

//  Parametrised sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one bit per clock.

---
 rtl/seq_multiplier_n.sv | 109 ++++++++++
 1 files changed

// File: rtl/seq_multiplier_n.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one bit per clock.
// Define SIGNED_MULT_EN to build a two's-complement Booth radix-2 variant instead.
module seq_multiplier_n #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ready,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t              state_q;
    logic [WIDTH:0]      acc_q, acc_d;
    logic [WIDTH-1:0]    q_q, q_d;
    logic [WIDTH-1:0]    m_q;
    logic [CW-1:0]       count_q;
    logic [2*WIDTH-1:0]  product_q;
    logic                ready_q;
    logic                done_q;
    logic [WIDTH:0]      sum;
`ifdef SIGNED_MULT_EN
    logic                q_m1_q, q_m1_d;
    logic [WIDTH:0]      m_ext;
`endif

    // One iteration: conditional add/subtract, then shift {acc,q} right by one.
    always_comb begin
        sum   = acc_q;
        acc_d = acc_q;
        q_d   = q_q;
`ifdef SIGNED_MULT_EN
        m_ext  = {m_q[WIDTH-1], m_q};
        q_m1_d = q_q[0];
        case ({q_q[0], q_m1_q})
            2'b01:   sum = acc_q + m_ext;
            2'b10:   sum = acc_q - m_ext;
            default: sum = acc_q;
        endcase
        acc_d = {sum[WIDTH], sum[WIDTH:1]};
`else
        // acc[WIDTH] is always 0 between iterations, so it acts as the carry-in slot.
        if (q_q[0])
            sum = acc_q + {1'b0, m_q};
        acc_d = {1'b0, sum[WIDTH:1]};
`endif
        q_d = {sum[0], q_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            q_q       <= '0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
`ifdef SIGNED_MULT_EN
            q_m1_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        q_q     <= multiplier;
                        m_q     <= multiplicand;
                        count_q <= CW'(WIDTH);
                        ready_q <= 1'b0;
                        state_q <= CALC;
`ifdef SIGNED_MULT_EN
                        q_m1_q  <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    q_q     <= q_d;
                    count_q <= count_q - CW'(1);
`ifdef SIGNED_MULT_EN
                    q_m1_q  <= q_m1_d;
`endif
                    if (count_q == CW'(1)) begin
                        product_q <= {acc_d[WIDTH-1:0], q_d};
                        done_q    <= 1'b1;
                        ready_q   <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign product = product_q;
    assign ready   = ready_q;
    assign done    = done_q;

endmodule
